// File: rtl/control_pkg.sv
// Shared pipeline-control types: forwarding selects, memory FSM states and a
// register-match helper used by the hazard and forwarding logic.
package control_pkg;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RSP  = 2'd2
  } mem_state_e;

  // x0 is hardwired to zero, so a write to it never creates a dependency
  function automatic logic reg_match(input logic [4:0] rd, input logic wen,
                                     input logic [4:0] rs);
    return wen && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Data-memory request/response handshake between the hazard controller and
// the data memory.
interface pipeline_hazard_ctrl_if;
  logic dmem_req_valid;
  logic dmem_req_ready;
  logic dmem_rsp_valid;

  modport master (
    output dmem_req_valid,
    input  dmem_req_ready,
    input  dmem_rsp_valid
  );

  modport slave (
    input  dmem_req_valid,
    output dmem_req_ready,
    output dmem_rsp_valid
  );
endinterface

// File: rtl/forward_unit.sv
// Forwarding select for one EX operand; the younger EX/MEM result wins over
// MEM/WB.
module forward_unit
  import control_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwen_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_regwen_i,
  output fwd_sel_e   sel_o
);

  always_comb begin
    sel_o = FWD_NONE;
    if (reg_match(mem_rd_i, mem_regwen_i, rs_i)) begin
      sel_o = FWD_EX_MEM;
    end else if (reg_match(wb_rd_i, wb_regwen_i, rs_i)) begin
      sel_o = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use bubbles, branch flushes and
// the MEM-stage data-memory handshake with its pipeline freeze.
module pipeline_hazard_ctrl
  import control_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [4:0]             id_rs1_i,
  input  logic [4:0]             id_rs2_i,
  input  logic                   id_use_rs1_i,
  input  logic                   id_use_rs2_i,
  input  logic [4:0]             ex_rs1_i,
  input  logic [4:0]             ex_rs2_i,
  input  logic [4:0]             ex_rd_i,
  input  logic                   ex_regwen_i,
  input  logic                   ex_is_load_i,
  input  logic [4:0]             mem_rd_i,
  input  logic                   mem_regwen_i,
  input  logic [4:0]             wb_rd_i,
  input  logic                   wb_regwen_i,
  input  logic                   ex_branch_taken_i,
  input  logic                   mem_op_valid_i,
  input  logic                   mem_op_is_load_i,
  pipeline_hazard_ctrl_if.master dmem_io,
  output fwd_sel_e               fwd_a_o,
  output fwd_sel_e               fwd_b_o,
  output logic                   stall_if_o,
  output logic                   stall_id_o,
  output logic                   stall_ex_o,
  output logic                   stall_mem_o,
  output logic                   flush_id_o,
  output logic                   flush_ex_o,
  output logic [XLEN-1:0]        stall_cycles_o,
  output logic [XLEN-1:0]        flush_events_o
);

  mem_state_e      state_q, state_d;
  logic            branch_pending_q, branch_pending_d;
  logic [XLEN-1:0] stall_cycles_q, flush_events_q;
  logic            freeze, load_use, stall_front;

  forward_unit u_fwd_a (
    .rs_i         (ex_rs1_i),
    .mem_rd_i     (mem_rd_i),
    .mem_regwen_i (mem_regwen_i),
    .wb_rd_i      (wb_rd_i),
    .wb_regwen_i  (wb_regwen_i),
    .sel_o        (fwd_a_o)
  );

  forward_unit u_fwd_b (
    .rs_i         (ex_rs2_i),
    .mem_rd_i     (mem_rd_i),
    .mem_regwen_i (mem_regwen_i),
    .wb_rd_i      (wb_rd_i),
    .wb_regwen_i  (wb_regwen_i),
    .sel_o        (fwd_b_o)
  );

  // Memory FSM; the only unfrozen MEM_REQ exit is an accepted store.
  always_comb begin
    state_d                = state_q;
    dmem_io.dmem_req_valid = 1'b0;
    freeze                 = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (mem_op_valid_i) begin
          freeze  = 1'b1;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        dmem_io.dmem_req_valid = 1'b1;
        if (dmem_io.dmem_req_ready) begin
          freeze  = mem_op_is_load_i;
          state_d = mem_op_is_load_i ? MEM_RSP : MEM_IDLE;
        end else begin
          freeze = 1'b1;
        end
      end
      MEM_RSP: begin
        if (dmem_io.dmem_rsp_valid) begin
          state_d = MEM_IDLE;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign load_use = ex_is_load_i &&
                    ((id_use_rs1_i && reg_match(ex_rd_i, ex_regwen_i, id_rs1_i)) ||
                     (id_use_rs2_i && reg_match(ex_rd_i, ex_regwen_i, id_rs2_i)));

  // Priority: freeze, then branch (live or deferred), then load-use bubble.
  always_comb begin
    stall_front      = 1'b0;
    stall_ex_o       = 1'b0;
    stall_mem_o      = 1'b0;
    flush_id_o       = 1'b0;
    flush_ex_o       = 1'b0;
    branch_pending_d = branch_pending_q;
    if (freeze) begin
      stall_front      = 1'b1;
      stall_ex_o       = 1'b1;
      stall_mem_o      = 1'b1;
      branch_pending_d = branch_pending_q | ex_branch_taken_i;
    end else if (ex_branch_taken_i || branch_pending_q) begin
      flush_id_o       = 1'b1;
      flush_ex_o       = 1'b1;
      branch_pending_d = 1'b0;
    end else if (load_use) begin
      stall_front = 1'b1;
      flush_ex_o  = 1'b1;
    end
  end

  assign stall_if_o = stall_front;
  assign stall_id_o = stall_front;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= MEM_IDLE;
      branch_pending_q <= 1'b0;
      stall_cycles_q   <= '0;
      flush_events_q   <= '0;
    end else begin
      state_q          <= state_d;
      branch_pending_q <= branch_pending_d;
      stall_cycles_q   <= stall_cycles_q + {{(XLEN-1){1'b0}}, stall_front};
      flush_events_q   <= flush_events_q + {{(XLEN-1){1'b0}}, flush_id_o};
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_events_o = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: expected per-cycle outputs are
// queued when stimulus is driven and compared when sampled on the falling edge.
module tb_pipeline_hazard_ctrl;
  import control_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] FN = FWD_NONE;
  localparam logic [1:0] FE = FWD_EX_MEM;
  localparam logic [1:0] FW = FWD_MEM_WB;
  localparam logic [3:0] FRZ = 4'b1111;
  localparam logic [3:0] LU  = 4'b1100;
  localparam logic [3:0] NS  = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwen, ex_is_load, mem_regwen, wb_regwen;
  logic ex_branch_taken, mem_op_valid, mem_op_is_load;
  fwd_sel_e fwd_a, fwd_b;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
  logic [XLEN-1:0] stall_cycles, flush_events;

  pipeline_hazard_ctrl_if dmem_if ();

  pipeline_hazard_ctrl #(.XLEN(XLEN)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_use_rs1_i      (id_use_rs1),
    .id_use_rs2_i      (id_use_rs2),
    .ex_rs1_i          (ex_rs1),
    .ex_rs2_i          (ex_rs2),
    .ex_rd_i           (ex_rd),
    .ex_regwen_i       (ex_regwen),
    .ex_is_load_i      (ex_is_load),
    .mem_rd_i          (mem_rd),
    .mem_regwen_i      (mem_regwen),
    .wb_rd_i           (wb_rd),
    .wb_regwen_i       (wb_regwen),
    .ex_branch_taken_i (ex_branch_taken),
    .mem_op_valid_i    (mem_op_valid),
    .mem_op_is_load_i  (mem_op_is_load),
    .dmem_io           (dmem_if.master),
    .fwd_a_o           (fwd_a),
    .fwd_b_o           (fwd_b),
    .stall_if_o        (stall_if),
    .stall_id_o        (stall_id),
    .stall_ex_o        (stall_ex),
    .stall_mem_o       (stall_mem),
    .flush_id_o        (flush_id),
    .flush_ex_o        (flush_ex),
    .stall_cycles_o    (stall_cycles),
    .flush_events_o    (flush_events)
  );

  typedef struct packed {
    logic       req;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] st;  // {if, id, ex, mem}
    logic [1:0] fl;  // {id, ex}
  } obs_t;

  obs_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_stalls, exp_flushes;

  function automatic obs_t mk(input logic req, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] st, input logic [1:0] fl);
    obs_t o;
    o.req = req; o.fa = fa; o.fb = fb; o.st = st; o.fl = fl;
    return o;
  endfunction

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwen = 0; ex_is_load = 0;
    mem_rd = 0; mem_regwen = 0; wb_rd = 0; wb_regwen = 0;
    ex_branch_taken = 0; mem_op_valid = 0; mem_op_is_load = 0;
    dmem_if.dmem_req_ready = 0; dmem_if.dmem_rsp_valid = 0;
  endtask

  task automatic sample(output obs_t o);
    o.req = dmem_if.dmem_req_valid;
    o.fa  = fwd_a;
    o.fb  = fwd_b;
    o.st  = {stall_if, stall_id, stall_ex, stall_mem};
    o.fl  = {flush_id, flush_ex};
  endtask

  // Advance one clock, accounting the expected counter effect of this cycle.
  task automatic tick(input obs_t e);
    if (e.st[3]) exp_stalls = exp_stalls + 1;
    if (e.fl[1]) exp_flushes = exp_flushes + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_stalls = '0;
    exp_flushes = '0;
    sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
    @(negedge clk);
    sample(o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", o, e);
    end
    n_cmp++;
    if (stall_cycles !== exp_stalls || flush_events !== exp_flushes) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want %0d/%0d",
               stall_cycles, flush_events, exp_stalls, exp_flushes);
    end
    tick(e);
  endtask

  task automatic test_load_use();
    obs_t o, e;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin
          ex_is_load = 1; ex_rd = 5; ex_regwen = 1; id_rs1 = 5; id_use_rs1 = 1;
          sb.push_back(mk(1'b0, FN, FN, LU, 2'b01));
        end
        1: sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));  // bubble now in EX
        2: begin
          ex_is_load = 1; ex_rd = 0; ex_regwen = 1; id_rs1 = 0; id_use_rs1 = 1;
          sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
        end
        3: begin
          ex_is_load = 1; ex_rd = 9; ex_regwen = 1; id_rs2 = 9; id_use_rs2 = 1;
          sb.push_back(mk(1'b0, FN, FN, LU, 2'b01));
        end
        4: begin
          ex_is_load = 1; ex_rd = 9; ex_regwen = 1; id_rs2 = 9; id_use_rs2 = 0;
          sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
        end
        default: begin
          ex_is_load = 0; ex_rd = 9; ex_regwen = 1; id_rs1 = 9; id_use_rs1 = 1;
          sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
        end
      endcase
      @(negedge clk);
      sample(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b want %b", i, o, e);
      end
      tick(e);
    end
    n_cmp++;
    if (stall_cycles !== exp_stalls) begin
      n_fail++;
      $display("FAIL load_use_stall_count: got %0d want %0d", stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_forwarding();
    obs_t o, e;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin
          mem_rd = 7; wb_rd = 7; ex_rs2 = 7; mem_regwen = 1; wb_regwen = 1;
          sb.push_back(mk(1'b0, FN, FE, NS, 2'b00));
        end
        1: begin
          mem_rd = 7; wb_rd = 7; ex_rs2 = 7; mem_regwen = 0; wb_regwen = 1;
          sb.push_back(mk(1'b0, FN, FW, NS, 2'b00));
        end
        2: begin
          mem_rd = 7; wb_rd = 7; ex_rs2 = 7; mem_regwen = 0; wb_regwen = 0;
          sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
        end
        3: begin
          mem_rd = 7; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 3; mem_regwen = 1; wb_regwen = 1;
          sb.push_back(mk(1'b0, FE, FN, NS, 2'b00));
        end
        4: begin
          mem_regwen = 1; wb_regwen = 1;  // all fields x0
          sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
        end
        default: begin
          mem_rd = 4; wb_rd = 4; ex_rs1 = 4; ex_rs2 = 4; wb_regwen = 1;
          sb.push_back(mk(1'b0, FW, FW, NS, 2'b00));
        end
      endcase
      @(negedge clk);
      sample(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL forwarding[%0d]: got %b want %b", i, o, e);
      end
      tick(e);
    end
  endtask

  task automatic test_load_txn();
    obs_t o, e;
    for (int i = 0; i < 8; i++) begin
      idle();
      mem_op_valid = (i <= 6);
      mem_op_is_load = 1;
      dmem_if.dmem_req_ready = (i == 3);
      dmem_if.dmem_rsp_valid = (i == 6);
      if (i == 0) sb.push_back(mk(1'b0, FN, FN, FRZ, 2'b00));
      else if (i <= 3) sb.push_back(mk(1'b1, FN, FN, FRZ, 2'b00));
      else if (i <= 5) sb.push_back(mk(1'b0, FN, FN, FRZ, 2'b00));
      else sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
      @(negedge clk);
      sample(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL load_txn[%0d]: got %b want %b", i, o, e);
      end
      tick(e);
    end
    n_cmp++;
    if (stall_cycles !== exp_stalls) begin
      n_fail++;
      $display("FAIL load_txn_stall_count: got %0d want %0d", stall_cycles, exp_stalls);
    end
  endtask

  task automatic test_store_txn();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      idle();
      mem_op_valid = (i <= 1);
      dmem_if.dmem_req_ready = (i == 1);
      if (i == 0) sb.push_back(mk(1'b0, FN, FN, FRZ, 2'b00));
      else if (i == 1) sb.push_back(mk(1'b1, FN, FN, NS, 2'b00));
      else sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
      @(negedge clk);
      sample(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL store_txn[%0d]: got %b want %b", i, o, e);
      end
      tick(e);
    end
  endtask

  task automatic test_branch_freeze();
    obs_t o, e;
    for (int i = 0; i < 6; i++) begin
      idle();
      mem_op_valid = (i <= 4);
      mem_op_is_load = 1;
      dmem_if.dmem_req_ready = (i == 1);
      dmem_if.dmem_rsp_valid = (i == 4);
      ex_branch_taken = (i == 2 || i == 3);
      if (i == 0) sb.push_back(mk(1'b0, FN, FN, FRZ, 2'b00));
      else if (i == 1) sb.push_back(mk(1'b1, FN, FN, FRZ, 2'b00));
      else if (i <= 3) sb.push_back(mk(1'b0, FN, FN, FRZ, 2'b00));
      else if (i == 4) sb.push_back(mk(1'b0, FN, FN, NS, 2'b11));
      else sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
      @(negedge clk);
      sample(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch_freeze[%0d]: got %b want %b", i, o, e);
      end
      tick(e);
    end
    n_cmp++;
    if (flush_events !== exp_flushes) begin
      n_fail++;
      $display("FAIL branch_freeze_flush_count: got %0d want %0d", flush_events, exp_flushes);
    end
  endtask

  task automatic test_branch_over_load_use();
    obs_t o, e;
    for (int i = 0; i < 2; i++) begin
      idle();
      if (i == 0) begin
        ex_branch_taken = 1;
        ex_is_load = 1; ex_rd = 12; ex_regwen = 1; id_rs1 = 12; id_use_rs1 = 1;
        sb.push_back(mk(1'b0, FN, FN, NS, 2'b11));
      end else begin
        sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
      end
      @(negedge clk);
      sample(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch_over_load_use[%0d]: got %b want %b", i, o, e);
      end
      tick(e);
    end
    n_cmp++;
    if (flush_events !== exp_flushes || stall_cycles !== exp_stalls) begin
      n_fail++;
      $display("FAIL branch_counts: got %0d/%0d want %0d/%0d",
               stall_cycles, flush_events, exp_stalls, exp_flushes);
    end
  endtask

  task automatic test_reset_in_req();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      idle();
      mem_op_valid = (i <= 1);
      rst = (i == 1);
      if (i == 0) sb.push_back(mk(1'b0, FN, FN, FRZ, 2'b00));
      else if (i == 1) sb.push_back(mk(1'b1, FN, FN, FRZ, 2'b00));
      else sb.push_back(mk(1'b0, FN, FN, NS, 2'b00));
      @(negedge clk);
      sample(o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_in_req[%0d]: got %b want %b", i, o, e);
      end
      tick(e);
      if (rst) begin
        exp_stalls = '0;
        exp_flushes = '0;
      end
    end
    rst = 1'b0;
    n_cmp++;
    if (stall_cycles !== exp_stalls || flush_events !== exp_flushes) begin
      n_fail++;
      $display("FAIL reset_in_req_counters: got %0d/%0d want %0d/%0d",
               stall_cycles, flush_events, exp_stalls, exp_flushes);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_load_txn();
    test_store_txn();
    test_branch_freeze();
    test_branch_over_load_use();
    test_reset_in_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
